// File: rtl/mul32x32_seq_ctrl.sv
// Sequencing controller for a 64-bit unsigned 32x32 product built from an external
// combinational 32x8 multiplier, one byte of B per cycle, with optional early exit.
module mul32x32_seq_ctrl #(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_p,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [7:0]  mul_b,
  input  logic [39:0] mul_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] b_r;
  logic [63:0] acc_r;
  logic [63:0] out_p_r;
  logic [1:0]  idx_r;
  logic [31:0] mul_a_r;
  logic [7:0]  mul_b_r;

  logic [63:0] acc_next_s;
  logic [1:0]  idx_next_s;
  logic [31:0] b_rem_s;
  logic [7:0]  next_byte_s;
  logic        last_step_s;

  // Accumulate the shifted partial product and decide whether this is the final step.
  always_comb begin
    acc_next_s  = acc_r + ({24'd0, mul_y} << {idx_r, 3'b000});
    idx_next_s  = idx_r + 2'd1;
    // Bytes of B above the current one; only meaningful while idx_r < 3.
    b_rem_s     = b_r >> {idx_next_s, 3'b000};
    next_byte_s = b_rem_s[7:0];
    if (idx_r == 2'd3) begin
      last_step_s = 1'b1;
    end else if ((EARLY_EXIT != 32'd0) && (b_rem_s == 32'd0)) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
  end

  // Control FSM with the multiplier operands and result held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      b_r     <= 32'd0;
      acc_r   <= 64'd0;
      out_p_r <= 64'd0;
      idx_r   <= 2'd0;
      mul_a_r <= 32'd0;
      mul_b_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            b_r     <= in_b;
            acc_r   <= 64'd0;
            idx_r   <= 2'd0;
            mul_a_r <= in_a;
            mul_b_r <= in_b[7:0];
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          if (last_step_s) begin
            out_p_r <= acc_next_s;
            mul_a_r <= 32'd0;
            mul_b_r <= 8'd0;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_next_s;
            mul_b_r <= next_byte_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_p     = out_p_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mul32x32_seq_ctrl.sv
// Randomized self-checking bench for mul32x32_seq_ctrl: one instance per EARLY_EXIT
// setting, a behavioural 32x8 multiplier each, and a product scoreboard.
module tb_mul32x32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;

  logic        ir0, ov0, bz0, ir1, ov1, bz1;
  logic [63:0] op0, op1;
  logic [31:0] ma0, ma1;
  logic [7:0]  mb0, mb1;
  logic [39:0] my0, my1;

  logic        o_in_ready, o_out_valid, o_busy;
  logic [63:0] o_out_p;
  logic [31:0] o_mul_a;
  logic [7:0]  o_mul_b;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          res_cnt = 0;
  logic [63:0] exp_q[$];
  int          acc_cyc[$];

  always #5 clk = ~clk;

  mul32x32_seq_ctrl #(.EARLY_EXIT(0)) dut_e0 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir0),
    .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_ready(out_ready),
    .out_p(op0), .busy(bz0), .mul_a(ma0), .mul_b(mb0), .mul_y(my0));

  mul32x32_seq_ctrl #(.EARLY_EXIT(1)) dut_e1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir1),
    .in_a(in_a), .in_b(in_b), .out_valid(ov1), .out_ready(out_ready),
    .out_p(op1), .busy(bz1), .mul_a(ma1), .mul_b(mb1), .mul_y(my1));

  assign my0 = 40'(ma0) * 40'(mb0);
  assign my1 = 40'(ma1) * 40'(mb1);

  assign o_in_ready  = sel ? ir1 : ir0;
  assign o_out_valid = sel ? ov1 : ov0;
  assign o_busy      = sel ? bz1 : bz0;
  assign o_out_p     = sel ? op1 : op0;
  assign o_mul_a     = sel ? ma1 : ma0;
  assign o_mul_b     = sel ? mb1 : mb0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int expected_steps(input logic [31:0] b, input logic ee);
    if (!ee) return 4;
    if (b >= 32'h0100_0000) return 4;
    if (b >= 32'h0001_0000) return 3;
    if (b >= 32'h0000_0100) return 2;
    return 1;
  endfunction

  // Scoreboard: products of accepted operands must come back in order.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && o_in_ready) begin
        exp_q.push_back(64'(in_a) * 64'(in_b));
        acc_cyc.push_back(cyc);
      end
      if (o_out_valid && out_ready) begin
        check_val("result_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_val("result", o_out_p, exp_q.pop_front());
        res_cnt <= res_cnt + 1;
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ee);
    int c;
    int k;
    @(negedge clk);
    sel = ee; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    check_val("in_ready_idle", 64'(o_in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    k = expected_steps(b, ee);
    c = 0;
    while (!o_out_valid && c < 16) begin
      if (c < 4) begin
        check_val("mul_b_step", 64'(o_mul_b), 64'((b >> (8 * c)) & 32'hFF));
        check_val("mul_a_step", 64'(o_mul_a), 64'(a));
      end
      @(negedge clk);
      c++;
    end
    check_val("latency", 64'(c), 64'(k));
    check_val("out_p", o_out_p, 64'(a) * 64'(b));
    check_val("done_mul_b", 64'(o_mul_b), 64'd0);
    @(negedge clk);
    check_val("idle_after_done", 64'({o_in_ready, o_out_valid, o_busy}), 64'b100);
  endtask

  initial begin
    logic [31:0] a, b, na, nb, r;
    int c, base, rbase;

    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(o_in_ready), 64'd1);
    check_val("rst_out_valid", 64'(o_out_valid), 64'd0);
    check_val("rst_busy", 64'(o_busy), 64'd0);
    check_val("rst_out_p", o_out_p, 64'd0);
    check_val("rst_mul", 64'({o_mul_a, o_mul_b}), 64'd0);
    rst = 1'b0;

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_val("full_scale", o_out_p, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h1234_5678, 32'h0000_0003, 1'b1);
    check_val("single_step", o_out_p, 64'h0000_0000_369D_0368);
    do_op(32'h8000_0000, 32'h0100_0000, 1'b1);
    check_val("top_byte", o_out_p, 64'h0080_0000_0000_0000);
    do_op(32'hDEAD_BEEF, 32'h0000_0000, 1'b1);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      r = $urandom;
      b = r >> (8 * $urandom_range(0, 4));
      do_op(a, b, 1'(i % 2));
    end

    // Backpressure: result held while new operands wait.
    a = $urandom; b = $urandom >> 8; na = $urandom; nb = $urandom;
    @(negedge clk);
    sel = 1'b1; out_ready = 1'b0; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!o_out_valid && c < 16) begin
      @(negedge clk);
      c++;
    end
    check_val("bp_latency", 64'(c), 64'(expected_steps(b, 1'b1)));
    in_valid = 1'b1; in_a = na; in_b = nb;
    base = acc_cyc.size();
    rbase = res_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_out_p", o_out_p, 64'(a) * 64'(b));
      check_val("bp_flags", 64'({o_in_ready, o_out_valid, o_busy}), 64'b011);
    end
    check_val("bp_no_accept", 64'(acc_cyc.size() - base), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release", 64'({o_in_ready, o_out_valid}), 64'b10);
    @(negedge clk);
    check_val("bp_accept", 64'(acc_cyc.size() - base), 64'd1);
    check_val("bp_busy", 64'(o_busy), 64'd1);
    in_valid = 1'b0;
    c = 0;
    while (res_cnt < rbase + 2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_val("bp_results", 64'(res_cnt - rbase), 64'd2);

    // Reset in the middle of CALC at idx 2.
    a = $urandom; b = $urandom;
    @(negedge clk);
    sel = 1'b0; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_idx2_mul_b", 64'(o_mul_b), 64'(b[23:16]));
    rbase = res_cnt;
    rst = 1'b1;
    #1;
    check_val("mid_rst_flags", 64'({o_in_ready, o_out_valid, o_busy}), 64'b100);
    check_val("mid_rst_mul", 64'({o_mul_a, o_mul_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("mid_rst_no_valid", 64'(o_out_valid), 64'd0);
    end
    check_val("mid_rst_no_result", 64'(res_cnt - rbase), 64'd0);
    do_op(32'd7, 32'd6, 1'b1);
    check_val("after_rst_42", o_out_p, 64'd42);

    // Back-to-back with in_valid and out_ready held high.
    base = acc_cyc.size();
    rbase = res_cnt;
    @(negedge clk);
    sel = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom;
      c = 0;
      while (acc_cyc.size() < base + i + 1 && c < 40) begin
        @(negedge clk);
        c++;
      end
    end
    in_valid = 1'b0;
    c = 0;
    while (res_cnt < rbase + 3 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check_val("b2b_results", 64'(res_cnt - rbase), 64'd3);
    check_val("b2b_accepts", 64'(acc_cyc.size() - base), 64'd3);
    if (acc_cyc.size() >= base + 3) begin
      check_val("b2b_gap1", 64'(acc_cyc[base + 1] - acc_cyc[base]), 64'd6);
      check_val("b2b_gap2", 64'(acc_cyc[base + 2] - acc_cyc[base + 1]), 64'd6);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
